// File: rtl/motor_current_guard.sv
// motor_current_guard: over-current guard for the left/right H-bridge drivers.
// Synchronizes and glitch-filters each comparator, trips into a timed cooldown,
// retries a bounded number of times and then latches a lockout until cleared.
// Optional build macro PER_SIDE_INHIBIT_EN: when defined, only the side(s) recorded
// in trip_side are inhibited; when undefined, both sides are inhibited on any fault.
module motor_current_guard #(
    parameter int unsigned FILTER_CYCLES   = 1000,
    parameter int unsigned COOLDOWN_CYCLES = 50000000,
    parameter int unsigned MAX_RETRIES     = 2,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       comp_left,
    input  logic       comp_right,
    input  logic       clear,
    output logic       inhibit_left,
    output logic       inhibit_right,
    output logic       current_protection,
    output logic       lockout,
    output logic [1:0] trip_side,
    output logic [1:0] retry_count
);

    localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0]    FILT_MAX = FW'(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] COOL_MAX = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [1:0]       MAX_R    = 2'(MAX_RETRIES);

    typedef enum logic [1:0] {StNormal, StTripped, StCooldown, StLockout} state_e;

    // Bit 1 is the left side, bit 0 the right side, matching trip_side.
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0][FW-1:0]  filt_q, filt_d;
    logic [1:0]          trip_q, trip_d;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [1:0]          retry_q, retry_d;
    logic [1:0]          side_q, side_d;
    logic [1:0]          inh_q, inh_d;
    logic                prot_q, prot_d;
    logic                lock_q, lock_d;

    // Two-flop synchronizers for the asynchronous comparator pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {comp_left, comp_right};
            sync2_q <= sync1_q;
        end
    end

    // Per-side run-length filter; the trip strobe is registered off the counter.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = '0;
            // TRIPPED clears and COOLDOWN holds the filters at zero.
            if ((state_q == StNormal || state_q == StLockout) && sync2_q[i]) begin
                filt_d[i] = (filt_q[i] == FILT_MAX) ? filt_q[i] : filt_q[i] + FW'(1);
            end
            trip_d[i] = (state_q == StNormal) && (filt_q[i] == FILT_MAX);
        end
    end

    // FSM next state, shared cooldown/clean-run counter, retry and trip-side tracking.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        side_d  = side_q;
        cnt_inc = cnt_q + CNT_W'(1);
        unique case (state_q)
            StNormal: begin
                if (|trip_q) begin
                    state_d = StTripped;
                    side_d  = trip_q;
                    cnt_d   = '0;
                end else if (cnt_inc == COOL_MAX) begin
                    // A full clean run forgives earlier trips.
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StTripped: begin
                retry_d = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
                cnt_d   = '0;
                state_d = (retry_d > MAX_R) ? StLockout : StCooldown;
            end
            StCooldown: begin
                // Exit is unconditional; a persisting fault re-trips through the filter.
                if (cnt_q == COOL_MAX) begin
                    state_d = StNormal;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StLockout: begin
                cnt_d = '0;
                if (clear && (sync2_q == 2'b00)) begin
                    state_d = StNormal;
                    retry_d = '0;
                end
            end
            default: state_d = StNormal;
        endcase
    end

    // Output decode from the next state so the outputs switch on the state edge.
    always_comb begin
        prot_d = (state_d != StNormal);
        lock_d = (state_d == StLockout);
`ifdef PER_SIDE_INHIBIT_EN
        inh_d  = side_d & {2{prot_d}};
`else
        inh_d  = {2{prot_d}};
`endif
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q  <= '0;
            trip_q  <= '0;
            state_q <= StNormal;
            cnt_q   <= '0;
            retry_q <= '0;
            side_q  <= '0;
            inh_q   <= '0;
            prot_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            trip_q  <= trip_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            side_q  <= side_d;
            inh_q   <= inh_d;
            prot_q  <= prot_d;
            lock_q  <= lock_d;
        end
    end

    assign inhibit_left       = inh_q[1];
    assign inhibit_right      = inh_q[0];
    assign current_protection = prot_q;
    assign lockout            = lock_q;
    assign trip_side          = side_q;
    assign retry_count        = retry_q;

endmodule

// File: tb/tb_motor_current_guard.sv
// tb_motor_current_guard: directed scenarios plus random comparator activity, checked
// every cycle against an edge-indexed behavioural model via an expectation queue.
module tb_motor_current_guard;

    localparam int F = 4;
    localparam int C = 20;
    localparam int M = 2;
    localparam int HMAX = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       comp_left = 1'b0;
    logic       comp_right = 1'b0;
    logic       clear = 1'b0;
    logic       inhibit_left, inhibit_right, current_protection, lockout;
    logic [1:0] trip_side, retry_count;

    motor_current_guard #(
        .FILTER_CYCLES  (F),
        .COOLDOWN_CYCLES(C),
        .MAX_RETRIES    (M),
        .CNT_W          (8)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .comp_left         (comp_left),
        .comp_right        (comp_right),
        .clear             (clear),
        .inhibit_left      (inhibit_left),
        .inhibit_right     (inhibit_right),
        .current_protection(current_protection),
        .lockout           (lockout),
        .trip_side         (trip_side),
        .retry_count       (retry_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       inh_l;
        logic       inh_r;
        logic       prot;
        logic       lock;
        logic [1:0] side;
        logic [1:0] retry;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   live = 0;

    // Reference model: comparator history indexed by clock edge number.
    bit hl[HMAX];
    bit hr[HMAX];
    int ed = -1;
    int valid_from = 0;
    int entry = 0;      // edge at which NORMAL was last entered
    int cd_entry = 0;   // edge at which COOLDOWN was entered
    int m_st = 0;       // 0 normal, 1 tripped, 2 cooldown, 3 lockout
    int m_retry = 0;
    bit [1:0] m_side = 2'b00;

    function automatic bit samp(bit left, int j);
        if (j < valid_from || j < 0 || j >= HMAX) return 1'b0;
        return left ? hl[j] : hr[j];
    endfunction

    // Side trips at edge e if its pin was high at the F sampled edges e-F-3..e-4,
    // all of which fall after the filter was last re-armed by entering NORMAL.
    function automatic bit run_high(bit left, int e);
        if (e - F - 3 < entry - 1) return 1'b0;
        for (int j = e - F - 3; j <= e - 4; j++) begin
            if (!samp(left, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            ed = ed + 1;
            if (ed < HMAX) begin
                hl[ed] = comp_left;
                hr[ed] = comp_right;
            end
            if (reset) begin
                live = 1;
                m_st = 0;
                m_retry = 0;
                m_side = 2'b00;
                entry = ed;
                valid_from = ed + 1;
            end else if (live) begin
                case (m_st)
                    0: begin
                        bit tl, tr;
                        tl = run_high(1'b1, ed);
                        tr = run_high(1'b0, ed);
                        if (tl || tr) begin
                            m_st = 1;
                            m_side = {tl, tr};
                        end else if (ed > entry && ((ed - entry) % C) == 0) begin
                            m_retry = 0;
                        end
                    end
                    1: begin
                        m_retry = (m_retry >= 3) ? 3 : m_retry + 1;
                        if (m_retry > M) m_st = 3;
                        else begin
                            m_st = 2;
                            cd_entry = ed;
                        end
                    end
                    2: begin
                        if (ed == cd_entry + C + 1) begin
                            m_st = 0;
                            entry = ed;
                        end
                    end
                    default: begin
                        if (clear && !samp(1'b1, ed - 2) && !samp(1'b0, ed - 2)) begin
                            m_st = 0;
                            m_retry = 0;
                            entry = ed;
                        end
                    end
                endcase
            end
            if (live) begin
                exp_t x;
                x.prot  = (m_st != 0);
                x.lock  = (m_st == 3);
`ifdef PER_SIDE_INHIBIT_EN
                x.inh_l = x.prot & m_side[1];
                x.inh_r = x.prot & m_side[0];
`else
                x.inh_l = x.prot;
                x.inh_r = x.prot;
`endif
                x.side  = m_side;
                x.retry = 2'(m_retry);
                exp_q.push_back(x);
            end
        end
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s at edge %0d: got %b, expected %b", name, ed, act, req);
        end
    endtask

    // Monitor: the DUT presents a registered output every cycle; compare #1 after the edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (live) begin
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    bad = bad + 1;
                    $display("FAIL scoreboard at edge %0d: got no expectation, expected one", ed);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("inhibit_left", {1'b0, inhibit_left}, {1'b0, x.inh_l});
                    check("inhibit_right", {1'b0, inhibit_right}, {1'b0, x.inh_r});
                    check("current_protection", {1'b0, current_protection}, {1'b0, x.prot});
                    check("lockout", {1'b0, lockout}, {1'b0, x.lock});
                    check("trip_side", trip_side, x.side);
                    check("retry_count", retry_count, x.retry);
                end
            end
        end
    end

    task automatic step(input logic l, input logic r, input logic c, input logic rs, input int n);
        repeat (n) begin
            @(negedge clock);
            comp_left = l;
            comp_right = r;
            clear = c;
            reset = rs;
        end
    endtask

    initial begin
        step(0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 5);
        // Glitch rejection: F-1 high cycles.
        step(1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 30);
        // Single right-side trip and cooldown.
        step(0, 1, 0, 0, 10);
        step(0, 0, 0, 0, 40);
        // Persistent left fault runs through all retries into lockout.
        step(1, 0, 0, 0, 320);
        // Clear gated by a still-high comparator, then accepted.
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 5);
        step(0, 0, 0, 0, 3);
        step(0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 30);
        // Retry decay after a clean run.
        step(0, 1, 0, 0, 6);
        step(0, 0, 0, 0, 60);
        step(0, 1, 0, 0, 6);
        step(0, 0, 0, 0, 40);
        // Simultaneous trip, then reset mid-cooldown.
        step(1, 1, 0, 0, 6);
        step(0, 0, 0, 0, 10);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 10);
        // Left-only trip.
        step(1, 0, 0, 0, 6);
        step(0, 0, 0, 0, 40);
        // Randomized comparator activity with occasional clear and reset.
        for (int i = 0; i < 80; i++) begin
            logic l, r, c;
            int n;
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 3) == 0);
            n = $urandom_range(1, 14);
            step(l, r, c, 0, 1);
            step(l, r, 0, 0, n);
            if ($urandom_range(0, 29) == 0) step(0, 0, 0, 1, 1);
        end
        step(0, 0, 0, 0, 5);
        @(posedge clock);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
